// File: rtl/mul_accum.sv
// mul_accum: accumulates fixed-length frames of unsigned products into a
// dot-product sum. The input side uses a valid/ready handshake, and the result
// port is registered valid/ready. The next frame may accumulate while the
// previous result is still pending. The pipeline stalls only when a frame's
// last product arrives while the previous result has not been taken.
//
// Optional feature: define MUL_ACCUM_SAT_EN to clamp the running sum and the
// result to all-ones on carry-out. Without it, the sum wraps modulo 2^ACC_W.
// In both builds out_ovf reports that the frame sum exceeded 2^ACC_W-1.
module mul_accum #(
    parameter int PROD_W    = 10,
    parameter int ACC_W     = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic               ovf_acc;
    logic [CNT_W-1:0]   cnt;

    logic               last;
    logic               accept;
    logic [ACC_W:0]     sum_ext;
    logic               carry;
    logic [ACC_W-1:0]   sum_val;

    assign last      = (cnt == LAST_CNT);
    assign out_valid = (state == FULL);
    // Depends only on registered state and out_ready, never on in_valid.
    assign in_ready  = !(last && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;

    assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    assign carry   = sum_ext[ACC_W];

    // Next running sum: wrap or clamp on carry-out, depending on the build.
    always_comb begin
        sum_val = sum_ext[ACC_W-1:0];
`ifdef MUL_ACCUM_SAT_EN
        if (carry) begin
            sum_val = '1;
        end
`endif
    end

    // Frame accumulation, result register and EMPTY/FULL result-port state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                state <= EMPTY;
            end
            if (accept) begin
                if (last) begin
                    // A last accept overrides the take in the same cycle, so
                    // back-to-back results leave no bubble.
                    out_sum <= sum_val;
                    out_ovf <= ovf_acc | carry;
                    state   <= FULL;
                    acc     <= '0;
                    ovf_acc <= 1'b0;
                    cnt     <= '0;
                end else begin
                    acc     <= sum_val;
                    ovf_acc <= ovf_acc | carry;
                    cnt     <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_accum.sv
// Self-checking bench for mul_accum. It uses three instances: default widths,
// a narrow ACC_W=12 accumulator that can overflow, and FRAME_LEN=1.
// Table-driven frame vectors, hand-written stall and reset sequences, and a
// randomized run checked against a frame-sum reference model.
module tb_mul_accum;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       in_valid = '0;
    logic [2:0]       out_ready = '1;
    logic [2:0][9:0]  in_prod = '0;
    logic [2:0]       in_ready;
    logic [2:0]       out_valid;
    logic [2:0]       out_ovf;
    logic [15:0]      sum0;
    logic [11:0]      sum1;
    logic [15:0]      sum2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mul_accum #(.PROD_W(10), .ACC_W(16), .FRAME_LEN(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_prod(in_prod[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum0), .out_ovf(out_ovf[0])
    );

    mul_accum #(.PROD_W(10), .ACC_W(12), .FRAME_LEN(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_prod(in_prod[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum1), .out_ovf(out_ovf[1])
    );

    mul_accum #(.PROD_W(10), .ACC_W(16), .FRAME_LEN(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_prod(in_prod[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(sum2), .out_ovf(out_ovf[2])
    );

    typedef struct {
        logic [7:0][9:0] p;
        int unsigned     wrap_sum;
        int unsigned     sat_sum;
        logic            ovf;
    } frame_vec_t;

    typedef struct {
        logic [9:0]  p;
        int unsigned sum;
    } single_vec_t;

    function automatic logic [15:0] sum_of(input int k);
        case (k)
            0:       return sum0;
            1:       return {4'b0000, sum1};
            default: return sum2;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Starts at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int k, input logic [9:0] v, output int stalls);
        logic r;
        r = 1'b0;
        stalls = 0;
        in_valid[k] = 1'b1;
        in_prod[k]  = v;
        for (int cyc = 0; cyc < 100; cyc++) begin
            #1 r = in_ready[k];
            @(posedge clk);
            @(negedge clk);
            if (r) break;
            stalls++;
        end
        in_valid[k] = 1'b0;
        if (!r) check("push_timeout", 32'(stalls), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic int unsigned exp_sum(input int unsigned s, input int w);
        int unsigned lim;
        lim = (32'd1 << w) - 1;
`ifdef MUL_ACCUM_SAT_EN
        return (s > lim) ? lim : s;
`else
        return s & lim;
`endif
    endfunction

    frame_vec_t  main_tab[4];
    frame_vec_t  narrow_tab[5];
    single_vec_t single_tab[5];

    initial begin
        int st;
        int total_stalls;
        int unsigned model_sum;
        int n_in_frame;
        int frames_sent;
        int results;
        int unsigned exp_q[$];
        logic ovf_q[$];
        logic hold;
        logic [15:0] hold_sum;
        logic hold_ovf;
        logic ov;
        logic [15:0] os;
        logic of;

        main_tab[0] = '{{10'd8, 10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1}, 36, 36, 1'b0};
        main_tab[1] = '{{8{10'd1023}}, 8184, 8184, 1'b0};
        main_tab[2] = '{{8{10'd0}}, 0, 0, 1'b0};
        main_tab[3] = '{{10'd512, 10'd0, 10'd1, 10'd300, 10'd77, 10'd1023, 10'd9, 10'd250}, 2172, 2172, 1'b0};

        narrow_tab[0] = '{{8{10'd1023}}, 4088, 4095, 1'b1};
        narrow_tab[1] = '{{10'd0, 10'd0, 10'd0, 10'd0, 10'd1023, 10'd1023, 10'd1023, 10'd1023}, 4092, 4092, 1'b0};
        narrow_tab[2] = '{{10'd0, 10'd0, 10'd0, 10'd3, 10'd1023, 10'd1023, 10'd1023, 10'd1023}, 4095, 4095, 1'b0};
        narrow_tab[3] = '{{10'd0, 10'd0, 10'd0, 10'd4, 10'd1023, 10'd1023, 10'd1023, 10'd1023}, 0, 4095, 1'b1};
        narrow_tab[4] = '{{10'd5, 10'd0, 10'd0, 10'd4, 10'd1023, 10'd1023, 10'd1023, 10'd1023}, 5, 4095, 1'b1};

        single_tab[0] = '{10'd5, 5};
        single_tab[1] = '{10'd0, 0};
        single_tab[2] = '{10'd1023, 1023};
        single_tab[3] = '{10'd512, 512};
        single_tab[4] = '{10'd1, 1};

        // Reset state of all instances.
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_out_valid", 32'(out_valid[k]), 0);
            check("rst_out_sum", 32'(sum_of(k)), 0);
            check("rst_out_ovf", 32'(out_ovf[k]), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready[0]), 1);

        // Main-width frame table, out_ready held high, no stalls expected.
        out_ready = '1;
        for (int i = 0; i < 4; i++) begin
            total_stalls = 0;
            for (int j = 0; j < 8; j++) begin
                push(0, main_tab[i].p[j], st);
                total_stalls += st;
            end
            check("main_stalls", 32'(total_stalls), 0);
            check("main_valid", 32'(out_valid[0]), 1);
            check("main_sum", 32'(sum0), 32'(main_tab[i].wrap_sum));
            check("main_ovf", 32'(out_ovf[0]), 32'(main_tab[i].ovf));
        end
        @(negedge clk);
        check("main_drain", 32'(out_valid[0]), 0);

        // Narrow accumulator: wrap vs saturate with overflow flag.
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 8; j++) push(1, narrow_tab[i].p[j], st);
            check("narrow_valid", 32'(out_valid[1]), 1);
`ifdef MUL_ACCUM_SAT_EN
            check("narrow_sum", 32'(sum1), 32'(narrow_tab[i].sat_sum));
`else
            check("narrow_sum", 32'(sum1), 32'(narrow_tab[i].wrap_sum));
`endif
            check("narrow_ovf", 32'(out_ovf[1]), 32'(narrow_tab[i].ovf));
        end

        // FRAME_LEN=1 streaming: one result per accept, one cycle later.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid[2] = 1'b1;
            in_prod[2]  = single_tab[i].p;
            #1 check("single_ready", 32'(in_ready[2]), 1);
            @(negedge clk);
            check("single_valid", 32'(out_valid[2]), 1);
            check("single_sum", 32'(sum2), 32'(single_tab[i].sum));
            check("single_ovf", 32'(out_ovf[2]), 0);
        end
        in_valid[2] = 1'b0;

        // Stall at last with a pending result, then release with no bubble.
        do_reset();
        out_ready[0] = 1'b0;
        for (int j = 0; j < 8; j++) push(0, 10'd1023, st);
        check("stall_f1_valid", 32'(out_valid[0]), 1);
        check("stall_f1_sum", 32'(sum0), 8184);
        for (int j = 0; j < 7; j++) push(0, 10'd1023, st);
        in_valid[0] = 1'b1;
        in_prod[0]  = 10'd1023;
        for (int c = 0; c < 3; c++) begin
            #1 check("stall_in_ready", 32'(in_ready[0]), 0);
            check("stall_hold_sum", 32'(sum0), 8184);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        #1 check("release_in_ready", 32'(in_ready[0]), 1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        check("release_valid", 32'(out_valid[0]), 1);
        check("release_sum", 32'(sum0), 8184);
        @(negedge clk);
        check("release_drain", 32'(out_valid[0]), 0);

        // Reset mid-frame with a pending result.
        out_ready[0] = 1'b0;
        for (int j = 0; j < 8; j++) push(0, main_tab[0].p[j], st);
        for (int j = 0; j < 3; j++) push(0, 10'd100, st);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid[0]), 0);
        check("midrst_sum", 32'(sum0), 0);
        check("midrst_ovf", 32'(out_ovf[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 8; j++) push(0, 10'd2, st);
        check("midrst_next_valid", 32'(out_valid[0]), 1);
        check("midrst_next_sum", 32'(sum0), 16);

        // Randomized gaps on both sides against a frame-sum reference.
        do_reset();
        model_sum = 0;
        n_in_frame = 0;
        frames_sent = 0;
        results = 0;
        hold = 1'b0;
        hold_sum = '0;
        hold_ovf = 1'b0;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            ov = out_valid[0];
            os = sum0;
            of = out_ovf[0];
            if (hold) begin
                check("rand_hold_valid", 32'(ov), 1);
                check("rand_hold_sum", 32'(os), 32'(hold_sum));
                check("rand_hold_ovf", 32'(of), 32'(hold_ovf));
            end
            out_ready[0] = ($urandom_range(0, 9) < 7);
            in_valid[0]  = (frames_sent < 1000) && ($urandom_range(0, 3) != 0);
            in_prod[0]   = 10'($urandom_range(0, 1023));
            #1;
            if (in_valid[0] && in_ready[0]) begin
                model_sum += 32'(in_prod[0]);
                n_in_frame++;
                if (n_in_frame == 8) begin
                    exp_q.push_back(exp_sum(model_sum, 16));
                    ovf_q.push_back(model_sum > 32'd65535);
                    model_sum = 0;
                    n_in_frame = 0;
                    frames_sent++;
                end
            end
            if (ov && out_ready[0]) begin
                if (exp_q.size() == 0) begin
                    check("rand_extra_result", 32'(results), 32'(frames_sent));
                end else begin
                    check("rand_sum", 32'(os), exp_q.pop_front());
                    check("rand_ovf", 32'(of), 32'(ovf_q.pop_front()));
                end
                results++;
            end
            hold     = ov && !out_ready[0];
            hold_sum = os;
            hold_ovf = of;
            @(negedge clk);
            if (frames_sent == 1000 && results == 1000) break;
        end
        in_valid[0] = 1'b0;
        check("rand_result_count", 32'(results), 1000);
        check("rand_queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
